alu_ex_stage: RTL

ALU_EX_STAGE -- requirements
Module: alu_ex_stage

---
 rtl/alu_ex_stage.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - 32-bit ALU execute stage with iterative (or optional barrel) shifter
//
// Purpose:
//   Executes one ALU op per accepted transfer and registers the result into
//   the EX/MEM output registers. Codes 0-6 and 10-15 complete in one cycle.
//   Shifts (codes 7-9) with a non-zero amount run one bit per cycle in the
//   SHIFT state. With EX_FAST_SHIFT_EN defined, shifts use a single-cycle
//   barrel shifter and the SHIFT state is never entered.
//
// Configuration macro: EX_FAST_SHIFT_EN
//
// Ports:
//   iClk, iRst          clock, synchronous active-high reset
//   iValid / oReady     upstream handshake, transfer = iValid & oReady
//   iALUctrl            op code (0 add, 1 sub, 2 and, 3 or, 4 slt, 5 xor,
//                       6 nor, 7 sll, 8 srl, 9 sra, 10-15 give zero)
//   iSrcA, iSrcB        operands; shifts operate on iSrcB
//   iShamt              shift amount for codes 7-9
//   iRd, iRegWrite      destination tag, passed through to oRd/oRegWrite
//   iStall              downstream hold
//   iFlush              kill in-flight op
//   oValid, oResult,
//   oZero, oRd,
//   oRegWrite           registered EX/MEM outputs
//   oBusy               high while an iterative shift is in progress

module alu_ex_stage (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iValid,
  output logic        oReady,
  input  logic [3:0]  iALUctrl,
  input  logic [31:0] iSrcA,
  input  logic [31:0] iSrcB,
  input  logic [4:0]  iShamt,
  input  logic [4:0]  iRd,
  input  logic        iRegWrite,
  input  logic        iStall,
  input  logic        iFlush,
  output logic        oValid,
  output logic [31:0] oResult,
  output logic        oZero,
  output logic [4:0]  oRd,
  output logic        oRegWrite,
  output logic        oBusy
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SLT = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOR = 4'd6;
  localparam logic [3:0] OP_SLL = 4'd7;
  localparam logic [3:0] OP_SRL = 4'd8;
  localparam logic [3:0] OP_SRA = 4'd9;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } stateT;

  stateT       state;
  stateT       stateNext;

  logic [31:0] aluResult;
  logic [31:0] workReg;
  logic [31:0] workShifted;
  logic [4:0]  count;
  logic [3:0]  shiftOp;
  logic [4:0]  pendRd;
  logic        pendRegWrite;

  logic        isShiftOp;
  logic        needIter;
  logic        startShift;
  logic        emitDirect;
  logic        stepShift;
  logic        emitShift;

  assign isShiftOp = (iALUctrl == OP_SLL) | (iALUctrl == OP_SRL) | (iALUctrl == OP_SRA);

`ifdef EX_FAST_SHIFT_EN
  assign needIter = 1'b0;
`else
  // A zero shift amount is just a pass-through of iSrcB and completes directly.
  assign needIter = isShiftOp & (iShamt != 5'd0);
`endif

  // Single-cycle result for everything that does not need the iterative path.
  always_comb begin
    aluResult = 32'd0;
    case (iALUctrl)
      OP_ADD: aluResult = iSrcA + iSrcB;
      OP_SUB: aluResult = iSrcA - iSrcB;
      OP_AND: aluResult = iSrcA & iSrcB;
      OP_OR:  aluResult = iSrcA | iSrcB;
      OP_SLT: aluResult = {31'd0, ($signed(iSrcA) < $signed(iSrcB))};
      OP_XOR: aluResult = iSrcA ^ iSrcB;
      OP_NOR: aluResult = ~(iSrcA | iSrcB);
`ifdef EX_FAST_SHIFT_EN
      OP_SLL: aluResult = iSrcB << iShamt;
      OP_SRL: aluResult = iSrcB >> iShamt;
      OP_SRA: aluResult = $signed(iSrcB) >>> iShamt;
`else
      // Only reaches the outputs when iShamt is zero.
      OP_SLL, OP_SRL, OP_SRA: aluResult = iSrcB;
`endif
      default: aluResult = 32'd0;
    endcase
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    workShifted = workReg;
    case (shiftOp)
      OP_SLL:  workShifted = {workReg[30:0], 1'b0};
      OP_SRL:  workShifted = {1'b0, workReg[31:1]};
      default: workShifted = {workReg[31], workReg[31:1]};
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // The final shift step and the write-back share an edge, so a shift by n
  // keeps the stage busy for exactly n cycles and completes with latency n+1.
  always_comb begin
    stateNext  = state;
    oReady     = 1'b0;
    oBusy      = 1'b0;
    startShift = 1'b0;
    emitDirect = 1'b0;
    stepShift  = 1'b0;
    emitShift  = 1'b0;
    case (state)
      IDLE: begin
        oReady = ~iStall & ~iFlush;
        if (iValid & ~iStall & ~iFlush) begin
          if (needIter) begin
            startShift = 1'b1;
            stateNext  = SHIFT;
          end else begin
            emitDirect = 1'b1;
          end
        end
      end
      SHIFT: begin
        oBusy = 1'b1;
        if (iFlush) begin
          stateNext = IDLE;
        end else if (~iStall) begin
          stepShift = 1'b1;
          if (count <= 5'd1) begin
            emitShift = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      count        <= 5'd0;
      workReg      <= 32'd0;
      shiftOp      <= 4'd0;
      pendRd       <= 5'd0;
      pendRegWrite <= 1'b0;
      oValid       <= 1'b0;
      oResult      <= 32'd0;
      oZero        <= 1'b1;
      oRd          <= 5'd0;
      oRegWrite    <= 1'b0;
    end else if (iFlush) begin
      // Flush wins over stall; result and tag registers keep stale data.
      count     <= 5'd0;
      oValid    <= 1'b0;
      oRegWrite <= 1'b0;
    end else if (~iStall) begin
      oValid <= 1'b0;
      if (emitDirect) begin
        oValid    <= 1'b1;
        oResult   <= aluResult;
        oZero     <= (aluResult == 32'd0);
        oRd       <= iRd;
        oRegWrite <= iRegWrite;
      end
      if (startShift) begin
        workReg      <= iSrcB;
        count        <= iShamt;
        shiftOp      <= iALUctrl;
        pendRd       <= iRd;
        pendRegWrite <= iRegWrite;
      end
      if (stepShift) begin
        workReg <= workShifted;
        count   <= count - 5'd1;
      end
      if (emitShift) begin
        oValid    <= 1'b1;
        oResult   <= workShifted;
        oZero     <= (workShifted == 32'd0);
        oRd       <= pendRd;
        oRegWrite <= pendRegWrite;
      end
    end
  end

endmodule
